ahb_slave_if: RTL and testbench
===============================

AHB_SLAVE_IF -- requirements
Module: ahb_slave_if

Interface
REQ-001 SHALL have port HCLK, input, 1, the single clock; all state updates on its rising edge.
REQ-002 SHALL have port HRESET, input, 1; reset is synchronous and active-high.
REQ-003 SHALL have port HSEL, input, 1, slave select from the address decoder.
REQ-004 SHALL have port HADDR, input, `AHB_ADDR_BITS, address-phase address.
REQ-005 SHALL have port HTRANS, input, 2: IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
REQ-006 SHALL have the following address-phase ports: HWRITE, input, 1, write=1; HSIZE, input, 3, 000 byte, 001 half, 010 word.
REQ-007 SHALL have port HWDATA, input, `AHB_DATA_BITS (32), data-phase write data.
REQ-008 SHALL have port HREADY, input, 1, global bus ready; it qualifies address-phase sampling.
REQ-009 SHALL have port HREADYOUT, output, 1; it is low while this slave stalls the data phase.
REQ-010 SHALL have port HRESP, output, 1: OKAY=0, ERROR=1.
REQ-011 SHALL have port HRDATA, output, 32, read data.
REQ-012 SHALL have the following back-end request outputs: mem_req, 1; mem_we, 1; mem_addr, 32; mem_wdata, 32; mem_wstrb, 4.
REQ-013 SHALL have the following back-end response inputs: mem_ack, 1, single-cycle completion pulse; mem_rdata, 32.
REQ-014 SHALL have parameter TIMEOUT, default 16, the maximum wait cycles for mem_ack before ERROR.

Function
REQ-015 SHALL capture a transfer only when HSEL & HREADY & HTRANS[1] are all high; captured fields are address, write, size and byte offset.
REQ-016 SHALL ignore BUSY and IDLE transfers; the slave SHALL respond with zero-wait-state OKAY (HREADYOUT=1, HRESP=0).
REQ-017 SHALL use the FSM states IDLE, ACCESS, ERR1, ERR2.
REQ-018 SHALL transition IDLE->ACCESS on a valid capture that is aligned and has HSIZE<=010.
REQ-019 SHALL transition IDLE->ERR1 on a valid capture that is misaligned (half with HADDR[0]=1, word with HADDR[1:0]!=0) or has HSIZE>010.
REQ-020 SHALL assert mem_req in ACCESS, holding mem_addr/mem_we/mem_wstrb stable until mem_ack.
REQ-021 SHALL drive mem_wdata from HWDATA, which is valid in the data phase (the ACCESS state).
REQ-022 SHALL derive mem_wstrb as follows: byte 0001<<off; half 0011<<off; word 1111; for reads it SHALL also reflect size.
REQ-023 SHALL hold HREADYOUT=0 in ACCESS until mem_ack; in the mem_ack cycle it SHALL drive HREADYOUT=1, HRESP=0, and HRDATA=mem_rdata (reads).
REQ-024 SHALL capture a new transfer back-to-back in the mem_ack cycle (pipelined address phase), going to ACCESS or ERR1 with no idle cycle.
REQ-025 SHALL transition ACCESS->IDLE on mem_ack when no new capture occurs.
REQ-026 SHALL use a wait counter that clears on entering ACCESS and increments each ACCESS cycle without mem_ack; on reaching TIMEOUT it SHALL drop mem_req and go to ERR1.
REQ-027 SHALL drive HREADYOUT=0, HRESP=1 in ERR1, and HREADYOUT=1, HRESP=1 in ERR2 (the two-cycle AHB error response).
REQ-028 SHALL transition ERR2->IDLE, or ERR2->capture of a new transfer if one is presented that cycle.
REQ-029 SHALL make no back-end access for an erroneous transfer: mem_req stays 0 throughout ERR1 and ERR2.
REQ-030 SHALL ignore a mem_ack arriving outside ACCESS.
REQ-031 SHALL hold HRDATA from its last value when no read completes.

Reset
REQ-032 SHALL place the following in reset on HRESET=1 at a clock edge: state IDLE, counter 0, mem_req 0, mem_we 0, mem_addr 0, mem_wstrb 0, HREADYOUT 1, HRESP 0, HRDATA 0.
REQ-033 SHALL abandon any transfer in progress when reset asserts mid-ACCESS; mem_req SHALL deassert the next cycle.

Structure
REQ-034 SHALL place the HTRANS, HSIZE and HRESP encodings, the FSM state enum and the data width in the shared package ahb_pkg.
REQ-035 SHALL implement the HSIZE/offset-to-strobe logic as the combinational sub-module ahb_wstrb_gen.

Verification
REQ-036 SHALL cover: word write NONSEQ to 0x1000_0004 with mem_ack after 2 cycles -> mem_wstrb=1111, HREADYOUT low for 2 cycles, then OKAY.
REQ-037 SHALL cover: byte read at 0x1000_0003 with mem_rdata=0xAABBCCDD -> mem_wstrb=1000, HRDATA=0xAABBCCDD on the ack cycle.
REQ-038 SHALL cover: word access at 0x1000_0002 -> ERR1 (HREADYOUT=0, HRESP=1), then ERR2 (HREADYOUT=1, HRESP=1), and mem_req never asserted.
REQ-039 SHALL cover: mem_ack never returned -> after 16 ACCESS cycles, a two-cycle ERROR response and mem_req=0.
REQ-040 SHALL cover: two back-to-back NONSEQ writes with immediate acks -> two mem_req pulses on consecutive cycles and no idle gap.
REQ-041 SHALL cover: HRESET pulsed mid-ACCESS -> all outputs at reset values the next cycle, followed by a clean transfer that completes OKAY.

Source files
------------

// File: rtl/ahb_pkg.sv
// Shared AHB encodings, FSM state type and bus widths for the AHB slave interface.
// Contents:
//   AhbAddrBits / AhbDataBits  bus widths
//   htrans_e, hsize_e, hresp_e AHB field encodings
//   state_e                    slave FSM states
//   xfer_bad()                 misaligned or unsupported-size check
package ahb_pkg;

  localparam int unsigned AhbAddrBits = 32;
  localparam int unsigned AhbDataBits = 32;
  localparam int unsigned AhbStrbBits = AhbDataBits / 8;

  typedef enum logic [1:0] {
    TransIdle   = 2'b00,
    TransBusy   = 2'b01,
    TransNonseq = 2'b10,
    TransSeq    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    SizeByte = 3'b000,
    SizeHalf = 3'b001,
    SizeWord = 3'b010
  } hsize_e;

  typedef enum logic {
    RespOkay  = 1'b0,
    RespError = 1'b1
  } hresp_e;

  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StAccess = 2'b01,
    StErr1   = 2'b10,
    StErr2   = 2'b11
  } state_e;

  // A transfer is refused when it is wider than a word or not naturally aligned.
  function automatic logic xfer_bad(input logic [2:0] size, input logic [1:0] off);
    logic bad;
    bad = 1'b0;
    if (size > SizeWord) begin
      bad = 1'b1;
    end else if (size == SizeHalf) begin
      bad = off[0];
    end else if (size == SizeWord) begin
      bad = (off != 2'b00);
    end
    return bad;
  endfunction

endpackage

// File: rtl/ahb_wstrb_gen.sv
// Byte-lane strobe generator: maps HSIZE and the low address bits to a 4-bit lane mask.
// Ports:
//   size   - HSIZE encoding (byte/half/word; larger sizes give no lanes)
//   offset - byte offset within the word (HADDR[1:0])
//   wstrb  - active byte lanes
module ahb_wstrb_gen
  import ahb_pkg::*;
(
  input  logic [2:0]             size,
  input  logic [1:0]             offset,
  output logic [AhbStrbBits-1:0] wstrb
);

  always_comb begin
    wstrb = '0;
    case (size)
      SizeByte: wstrb = 4'b0001 << offset;
      SizeHalf: wstrb = 4'b0011 << offset;
      SizeWord: wstrb = 4'b1111;
      default:  wstrb = '0;
    endcase
  end

endmodule

// File: rtl/ahb_slave_if.sv
// AHB-Lite slave front end that turns bus transfers into single back-end requests.
// Ports:
//   HCLK, HRESET                 clock, synchronous active-high reset
//   HSEL, HADDR, HTRANS, HWRITE,
//   HSIZE, HREADY                address phase
//   HWDATA                       write data (data phase)
//   HREADYOUT, HRESP, HRDATA     data-phase response
//   mem_req, mem_we, mem_addr,
//   mem_wdata, mem_wstrb         back-end request, held until mem_ack
//   mem_ack, mem_rdata           back-end single-cycle completion and read data
// Parameter TIMEOUT: ACCESS cycles allowed without mem_ack before an ERROR response.
module ahb_slave_if
  import ahb_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                   HCLK,
  input  logic                   HRESET,
  input  logic                   HSEL,
  input  logic [AhbAddrBits-1:0] HADDR,
  input  logic [1:0]             HTRANS,
  input  logic                   HWRITE,
  input  logic [2:0]             HSIZE,
  input  logic [AhbDataBits-1:0] HWDATA,
  input  logic                   HREADY,
  output logic                   HREADYOUT,
  output logic                   HRESP,
  output logic [AhbDataBits-1:0] HRDATA,
  output logic                   mem_req,
  output logic                   mem_we,
  output logic [AhbAddrBits-1:0] mem_addr,
  output logic [AhbDataBits-1:0] mem_wdata,
  output logic [AhbStrbBits-1:0] mem_wstrb,
  input  logic                   mem_ack,
  input  logic [AhbDataBits-1:0] mem_rdata
);

  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  state_e                 state_q, state_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [AhbAddrBits-1:0] addr_q, addr_d;
  logic                   we_q, we_d;
  logic [AhbStrbBits-1:0] wstrb_q, wstrb_d;
  logic [AhbDataBits-1:0] rdata_q, rdata_d;

  logic                   capture;
  logic                   take;
  logic [AhbStrbBits-1:0] strb_new;

  ahb_wstrb_gen u_wstrb_gen (
    .size   (HSIZE),
    .offset (HADDR[1:0]),
    .wstrb  (strb_new)
  );

  // Only NONSEQ/SEQ count; IDLE and BUSY get the default zero-wait OKAY.
  assign capture = HSEL & HREADY & ((HTRANS == TransNonseq) | (HTRANS == TransSeq));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    we_d      = we_q;
    wstrb_d   = wstrb_q;
    rdata_d   = rdata_q;
    take      = 1'b0;
    mem_req   = 1'b0;
    HREADYOUT = 1'b1;
    HRESP     = RespOkay;

    unique case (state_q)
      StIdle: begin
        take = 1'b1;
      end
      StAccess: begin
        mem_req   = 1'b1;
        HREADYOUT = mem_ack;
        if (mem_ack) begin
          state_d = StIdle;
          take    = 1'b1;
          if (!we_q) begin
            rdata_d = mem_rdata;
          end
        end else if (cnt_q == CntLast) begin
          // Back end never answered: abandon and report ERROR.
          state_d = StErr1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StErr1: begin
        HREADYOUT = 1'b0;
        HRESP     = RespError;
        state_d   = StErr2;
      end
      StErr2: begin
        HRESP   = RespError;
        state_d = StIdle;
        take    = 1'b1;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Address phase can overlap the last cycle of the previous data phase.
    if (take && capture) begin
      if (xfer_bad(HSIZE, HADDR[1:0])) begin
        state_d = StErr1;
      end else begin
        state_d = StAccess;
        cnt_d   = '0;
        addr_d  = HADDR;
        we_d    = HWRITE;
        wstrb_d = strb_new;
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wstrb_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wstrb_q <= wstrb_d;
      rdata_q <= rdata_d;
    end
  end

  // Read data passes through on the ack cycle and is held afterwards.
  assign HRDATA    = rdata_d;
  assign mem_addr  = addr_q;
  assign mem_we    = we_q;
  assign mem_wstrb = wstrb_q;
  assign mem_wdata = HWDATA;

endmodule

// File: tb/tb_ahb_slave_if.sv
// Directed bench for ahb_slave_if with a back-end request scoreboard.
module tb_ahb_slave_if;

  logic        hclk = 1'b0;
  logic        hreset;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [31:0] hwdata;
  logic        hready;
  logic        hreadyout;
  logic        hresp;
  logic [31:0] hrdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } exp_t;

  exp_t exp_q[$];

  always #5 hclk = ~hclk;

  // Single slave on the bus: global HREADY is this slave's HREADYOUT.
  assign hready = hreadyout;

  ahb_slave_if #(.TIMEOUT(16)) dut (
    .HCLK      (hclk),
    .HRESET    (hreset),
    .HSEL      (hsel),
    .HADDR     (haddr),
    .HTRANS    (htrans),
    .HWRITE    (hwrite),
    .HSIZE     (hsize),
    .HWDATA    (hwdata),
    .HREADY    (hready),
    .HREADYOUT (hreadyout),
    .HRESP     (hresp),
    .HRDATA    (hrdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge.
  task automatic step();
    @(posedge hclk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic addr_phase(input logic [31:0] a, input logic w, input logic [2:0] s);
    hsel   = 1'b1;
    htrans = 2'b10;
    haddr  = a;
    hwrite = w;
    hsize  = s;
  endtask

  task automatic bus_idle();
    hsel   = 1'b0;
    htrans = 2'b00;
  endtask

  task automatic push(input logic [31:0] a, input logic w, input logic [3:0] st,
                      input logic [31:0] d);
    exp_t e;
    e.addr  = a;
    e.we    = w;
    e.wstrb = st;
    e.wdata = d;
    exp_q.push_back(e);
  endtask

  // Every accepted back-end request must match the oldest expected one.
  always @(negedge hclk) begin
    if (!hreset && mem_req && mem_ack) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_req", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sb_addr", mem_addr, e.addr);
        chk("sb_we", {31'd0, mem_we}, {31'd0, e.we});
        chk("sb_wstrb", {28'd0, mem_wstrb}, {28'd0, e.wstrb});
        if (e.we) chk("sb_wdata", mem_wdata, e.wdata);
      end
    end
  end

  initial begin
    int n_req;
    hreset    = 1'b1;
    hsel      = 1'b0;
    haddr     = '0;
    htrans    = 2'b00;
    hwrite    = 1'b0;
    hsize     = 3'b000;
    hwdata    = '0;
    mem_ack   = 1'b0;
    mem_rdata = '0;

    // Reset state
    step(); step();
    hreset = 1'b0;
    settle();
    chk("rst_hreadyout", {31'd0, hreadyout}, 32'd1);
    chk("rst_hresp", {31'd0, hresp}, 32'd0);
    chk("rst_hrdata", hrdata, 32'd0);
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wstrb", {28'd0, mem_wstrb}, 32'd0);

    // Word write with ack in the third data-phase cycle
    step();
    addr_phase(32'h1000_0004, 1'b1, 3'b010);
    push(32'h1000_0004, 1'b1, 4'b1111, 32'h1122_3344);
    step();
    bus_idle();
    hwdata = 32'h1122_3344;
    settle();
    chk("w_wait1_hready", {31'd0, hreadyout}, 32'd0);
    chk("w_wait1_req", {31'd0, mem_req}, 32'd1);
    chk("w_wstrb", {28'd0, mem_wstrb}, 32'hf);
    step();
    settle();
    chk("w_wait2_hready", {31'd0, hreadyout}, 32'd0);
    step();
    mem_ack = 1'b1;
    settle();
    chk("w_ack_hready", {31'd0, hreadyout}, 32'd1);
    chk("w_ack_hresp", {31'd0, hresp}, 32'd0);
    step();
    mem_ack = 1'b0;
    settle();
    chk("w_after_req", {31'd0, mem_req}, 32'd0);

    // Byte read at offset 3
    addr_phase(32'h1000_0003, 1'b0, 3'b000);
    push(32'h1000_0003, 1'b0, 4'b1000, 32'h0);
    step();
    bus_idle();
    mem_ack   = 1'b1;
    mem_rdata = 32'hAABB_CCDD;
    settle();
    chk("r_wstrb", {28'd0, mem_wstrb}, 32'h8);
    chk("r_hrdata", hrdata, 32'hAABB_CCDD);
    chk("r_hready", {31'd0, hreadyout}, 32'd1);
    step();
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    settle();
    chk("r_hrdata_hold", hrdata, 32'hAABB_CCDD);

    // Misaligned word: two-cycle ERROR, stray ack ignored
    addr_phase(32'h1000_0002, 1'b1, 3'b010);
    step();
    bus_idle();
    mem_ack = 1'b1;
    settle();
    chk("e1_hready", {31'd0, hreadyout}, 32'd0);
    chk("e1_hresp", {31'd0, hresp}, 32'd1);
    chk("e1_req", {31'd0, mem_req}, 32'd0);
    step();
    mem_ack = 1'b0;
    settle();
    chk("e2_hready", {31'd0, hreadyout}, 32'd1);
    chk("e2_hresp", {31'd0, hresp}, 32'd1);
    chk("e2_req", {31'd0, mem_req}, 32'd0);
    step();
    settle();
    chk("e_done_hresp", {31'd0, hresp}, 32'd0);

    // Timeout: mem_ack never returned
    addr_phase(32'h2000_0000, 1'b0, 3'b010);
    step();
    bus_idle();
    n_req = 0;
    for (int i = 0; i < 40; i++) begin
      settle();
      if (hresp) break;
      if (mem_req) n_req++;
      step();
    end
    chk("to_access_cycles", n_req, 32'd16);
    chk("to_e1_hready", {31'd0, hreadyout}, 32'd0);
    chk("to_e1_hresp", {31'd0, hresp}, 32'd1);
    chk("to_e1_req", {31'd0, mem_req}, 32'd0);
    step();
    settle();
    chk("to_e2_hready", {31'd0, hreadyout}, 32'd1);
    chk("to_e2_hresp", {31'd0, hresp}, 32'd1);
    chk("to_e2_req", {31'd0, mem_req}, 32'd0);
    step();

    // Back-to-back writes with immediate acks
    addr_phase(32'h3000_0000, 1'b1, 3'b010);
    push(32'h3000_0000, 1'b1, 4'b1111, 32'hCAFE_0001);
    step();
    addr_phase(32'h3000_0006, 1'b1, 3'b001);
    push(32'h3000_0006, 1'b1, 4'b1100, 32'hCAFE_0002);
    hwdata  = 32'hCAFE_0001;
    mem_ack = 1'b1;
    settle();
    chk("b2b_req1", {31'd0, mem_req}, 32'd1);
    chk("b2b_hready1", {31'd0, hreadyout}, 32'd1);
    step();
    bus_idle();
    hwdata = 32'hCAFE_0002;
    settle();
    chk("b2b_req2", {31'd0, mem_req}, 32'd1);
    chk("b2b_addr2", mem_addr, 32'h3000_0006);
    step();
    mem_ack = 1'b0;
    settle();
    chk("b2b_after_req", {31'd0, mem_req}, 32'd0);

    // Reset mid-ACCESS, then a clean read
    addr_phase(32'h4000_0008, 1'b1, 3'b010);
    step();
    bus_idle();
    settle();
    chk("rm_req", {31'd0, mem_req}, 32'd1);
    hreset = 1'b1;
    step();
    hreset = 1'b0;
    settle();
    chk("rm_req_off", {31'd0, mem_req}, 32'd0);
    chk("rm_addr", mem_addr, 32'd0);
    chk("rm_wstrb", {28'd0, mem_wstrb}, 32'd0);
    chk("rm_we", {31'd0, mem_we}, 32'd0);
    chk("rm_hready", {31'd0, hreadyout}, 32'd1);
    chk("rm_hresp", {31'd0, hresp}, 32'd0);
    chk("rm_hrdata", hrdata, 32'd0);
    step();
    addr_phase(32'h4000_0010, 1'b0, 3'b010);
    push(32'h4000_0010, 1'b0, 4'b1111, 32'h0);
    step();
    bus_idle();
    settle();
    chk("cl_wait_hready", {31'd0, hreadyout}, 32'd0);
    step();
    mem_ack   = 1'b1;
    mem_rdata = 32'h5A5A_1234;
    settle();
    chk("cl_hrdata", hrdata, 32'h5A5A_1234);
    chk("cl_hresp", {31'd0, hresp}, 32'd0);
    chk("cl_hready", {31'd0, hreadyout}, 32'd1);
    step();
    mem_ack = 1'b0;
    settle();
    chk("sb_empty", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
